alu_ctrl_decode_e: RTL
======================

Name: alu_ctrl_decode_e

Overview:
- ID-stage decoder plus ID/EX pipeline register that produces the 4-bit ALU control code and operand-source selects consumed by the EX-stage ALU.
- Decodes RV32I opcode/funct3/funct7 and generates the immediate.
- Registers all results at the ID/EX boundary, with stall (bubble) and flush control from the hazard unit.

Parameters:
- XLEN, 32, datapath/immediate width (only 32 supported).
- NOP_ALU, 4'd3, ALU code driven on reset/flush (ADD).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-high reset
- bubble_e  input  1  stall: hold ID/EX contents
- flush_e  input  1  replace ID/EX contents with NOP
- inst_d  input  32  instruction word in ID
- inst_valid_d  input  1  inst_d is a real instruction
- alu_contrl_e  output  4  ALU operation code for EX
- alu_src1_e  output  2  operand1 select: 00 rs1 value, 01 PC, 10 imm_e (zimm)
- alu_src2_e  output  2  operand2 select: 00 rs2 value, 01 imm_e, 10 CSR read value
- imm_e  output  32  decoded immediate
- valid_e  output  1  EX slot holds a real instruction
- illegal_e  output  1  instruction in EX is undecodable

Behaviour:
- Clock/reset: one clock domain, clk. Reset is rst, synchronous and active-high.
- All outputs are registered. Decode of inst_d appears one cycle later. There is no combinational path from inputs to outputs.
- Update priority each posedge: rst > flush_e > bubble_e > load.
- Reset/flush values: alu_contrl_e=NOP_ALU, src selects 00, imm_e=0, valid_e=0, illegal_e=0.
- bubble_e=1 and flush_e=0: every output holds. flush_e wins over bubble_e.
- inst_valid_d=0 on a load cycle: loads the flush values.
- ALU codes (shared constants): SLL 0, SRL 1, SRA 2, ADD 3, SUB 4, XOR 5, OR 6, AND 7, SLT 8, SLTU 9, LUI 10, CLR 11, REG1 12.
- OP (0110011), funct7=0000000, src2=00: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- OP, funct7=0100000: funct3 000 SUB, 101 SRA. Any other funct7/funct3 pair is illegal.
- OP-IMM (0010011): src2=01, I-immediate, same mapping without SUB.
  - SLLI requires funct7=0000000.
  - funct3 101 uses funct7 0000000 → SRL, 0100000 → SRA.
  - Any other funct7 on a shift is illegal.
- LUI (0110111): LUI, src2=01, U-immediate (low 12 bits zero).
- AUIPC (0010111): ADD, src1=01, src2=01, U-immediate.
- JALR (1100111, funct3=000) and loads (0000011): ADD, src2=01, I-immediate.
- Stores (0100011): ADD, src2=01, S-immediate.
- JAL (1101111): ADD, src1=01, src2=01, J-immediate.
- BRANCH (1100011): ADD, src2=00, B-immediate. The comparison is done outside the ALU.
- Immediates are sign-extended from bit 31 of inst_d.
- Illegal decode: valid_e=1, illegal_e=1, alu_contrl_e=NOP_ALU, selects 00, imm_e=0.
- Unknown opcode is illegal. inst_d=32'h00000013 decodes as ADD (canonical NOP), valid_e=1.

Optional Feature:
- Macro: CSR_DECODE_EN.
- Defined: SYSTEM (1110011) decodes as follows, all with src2=10:
  - funct3 001 CSRRW → REG1, src1=00.
  - funct3 010 CSRRS → OR, src1=00.
  - funct3 011 CSRRC → CLR, src1=00.
  - funct3 101/110/111 (immediate forms): same codes with src1=10 and imm_e={27'b0, inst_d[19:15]}.
  - funct3 000 or 100: illegal.
- Not defined: every SYSTEM encoding is illegal, and codes 11/12 are never produced.

Decomposition:
- Shared constants file: ALU codes, opcode constants, src-select encodings, NOP_ALU.
- One natural sub-module, imm_gen: combinational I/S/B/U/J/zimm immediate extraction, selected by an immediate-type code from the decoder.

Test Plan:
- rst=1 for 2 cycles with inst_d=32'h40B50533 (sub) → all outputs at reset values. First load after rst drops → alu_contrl_e=4, valid_e=1.
- inst_d=32'h4020D093 (srai x1,x1,2) → next cycle alu_contrl_e=2, src2=01, imm_e=32'h00000402. inst_d=32'h0020D093 (srli) → 1.
- inst_d=32'hFFFFF2B7 (lui) → LUI, imm_e=32'hFFFFF000. inst_d=32'hFFC52503 (lw -4) → ADD, imm_e=32'hFFFFFFFC.
- Load sub, then bubble_e=1 for 3 cycles while inst_d changes → outputs stay SUB. Then flush_e=1 with bubble_e=1 → NOP, valid_e=0.
- inst_d=32'h02000033 (funct7=0000001) and 32'h0000007F → illegal_e=1, valid_e=1, alu_contrl_e=3.
- With CSR_DECODE_EN, inst_d=32'h3000B073 (csrrc) → alu_contrl_e=11, src2=10. With 32'h30015073 (csrrwi x0,mstatus,2) → 12, src1=10, imm_e=2. Without the macro, both → illegal_e=1.

Source files
------------

// File: rtl/alu_ctrl_decode_e_pkg.sv
// Shared constants for the ID-stage ALU control decoder: ALU codes, RV32I opcodes,
// operand-source selects and the immediate-type code used by imm_gen.
package alu_ctrl_decode_e_pkg;

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRL  = 4'd1;
  localparam logic [3:0] ALU_SRA  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_CLR  = 4'd11;
  localparam logic [3:0] ALU_REG1 = 4'd12;

  localparam logic [3:0] NOP_ALU_DEFAULT = ALU_ADD;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] SRC1_RS1  = 2'b00;
  localparam logic [1:0] SRC1_PC   = 2'b01;
  localparam logic [1:0] SRC1_ZIMM = 2'b10;

  localparam logic [1:0] SRC2_RS2 = 2'b00;
  localparam logic [1:0] SRC2_IMM = 2'b01;
  localparam logic [1:0] SRC2_CSR = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_t;

  // Base funct3 mapping shared by OP (funct7=0) and OP-IMM; shifts are refined by the caller.
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_decode_e_imm_gen.sv
// Combinational RV32I immediate extraction (I/S/B/U/J and CSR zimm), selected by
// the decoder's immediate-type code. Takes inst[31:7]; the opcode field is not needed.
module alu_ctrl_decode_e_imm_gen
  import alu_ctrl_decode_e_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst,
  input  imm_type_t       imm_sel,
  output logic [XLEN-1:0] imm
);

  logic sign;
  assign sign = inst[31];

  // NOTE: every path of a combinational case assigns imm; the default arm keeps it latch-free.
  always_comb begin
    case (imm_sel)
      IMM_I:   imm = {{20{sign}}, inst[31:20]};
      IMM_S:   imm = {{20{sign}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{sign}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{sign}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_Z:   imm = {27'b0, inst[19:15]};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_decode_e.sv
// RV32I ID-stage ALU control decoder with ID/EX pipeline register (stall/flush).
// Optional CSR instruction decode is enabled by defining CSR_DECODE_EN.
module alu_ctrl_decode_e
  import alu_ctrl_decode_e_pkg::*;
#(
  parameter int         XLEN    = 32,
  parameter logic [3:0] NOP_ALU = NOP_ALU_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bubble_e,
  input  logic            flush_e,
  input  logic [31:0]     inst_d,
  input  logic            inst_valid_d,
  output logic [3:0]      alu_contrl_e,
  output logic [1:0]      alu_src1_e,
  output logic [1:0]      alu_src2_e,
  output logic [XLEN-1:0] imm_e,
  output logic            valid_e,
  output logic            illegal_e
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst_d[6:0];
  assign funct3 = inst_d[14:12];
  assign funct7 = inst_d[31:25];

  logic [3:0]      dec_alu;
  logic [1:0]      dec_src1;
  logic [1:0]      dec_src2;
  imm_type_t       dec_imm_sel;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_imm;

  always_comb begin
    dec_alu     = ALU_ADD;
    dec_src1    = SRC1_RS1;
    dec_src2    = SRC2_RS2;
    dec_imm_sel = IMM_NONE;
    dec_illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE)
          dec_alu = alu_from_funct3(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000)
          dec_alu = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)
          dec_alu = ALU_SRA;
        else
          dec_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec_src2    = SRC2_IMM;
        dec_imm_sel = IMM_I;
        dec_alu     = alu_from_funct3(funct3);
        // Shift-immediates reuse funct7 to pick the shift kind; the rest of the imm is free.
        if (funct3 == 3'b001 && funct7 != F7_BASE)
          dec_illegal = 1'b1;
        else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)       dec_alu = ALU_SRA;
          else if (funct7 != F7_BASE) dec_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_alu     = ALU_LUI;
        dec_src2    = SRC2_IMM;
        dec_imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        dec_src1    = SRC1_PC;
        dec_src2    = SRC2_IMM;
        dec_imm_sel = IMM_U;
      end
      OPC_JALR: begin
        dec_src2    = SRC2_IMM;
        dec_imm_sel = IMM_I;
        dec_illegal = (funct3 != 3'b000);
      end
      OPC_LOAD: begin
        dec_src2    = SRC2_IMM;
        dec_imm_sel = IMM_I;
      end
      OPC_STORE: begin
        dec_src2    = SRC2_IMM;
        dec_imm_sel = IMM_S;
      end
      OPC_JAL: begin
        dec_src1    = SRC1_PC;
        dec_src2    = SRC2_IMM;
        dec_imm_sel = IMM_J;
      end
      OPC_BRANCH: begin
        dec_imm_sel = IMM_B;
      end
`ifdef CSR_DECODE_EN
      OPC_SYSTEM: begin
        dec_src2 = SRC2_CSR;
        case (funct3[1:0])
          2'b01:   dec_alu = ALU_REG1;
          2'b10:   dec_alu = ALU_OR;
          2'b11:   dec_alu = ALU_CLR;
          default: dec_illegal = 1'b1;
        endcase
        if (funct3[2]) begin
          dec_src1    = SRC1_ZIMM;
          dec_imm_sel = IMM_Z;
        end
      end
`endif
      default: dec_illegal = 1'b1;
    endcase

    // Illegal instructions travel down the pipe as a flagged NOP.
    if (dec_illegal) begin
      dec_alu     = NOP_ALU;
      dec_src1    = SRC1_RS1;
      dec_src2    = SRC2_RS2;
      dec_imm_sel = IMM_NONE;
    end
  end

  alu_ctrl_decode_e_imm_gen #(
    .XLEN (XLEN)
  ) u_imm_gen (
    .inst    (inst_d[31:7]),
    .imm_sel (dec_imm_sel),
    .imm     (dec_imm)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || flush_e || (!bubble_e && !inst_valid_d)) begin
      alu_contrl_e <= NOP_ALU;
      alu_src1_e   <= SRC1_RS1;
      alu_src2_e   <= SRC2_RS2;
      imm_e        <= '0;
      valid_e      <= 1'b0;
      illegal_e    <= 1'b0;
    end else if (!bubble_e) begin
      alu_contrl_e <= dec_alu;
      alu_src1_e   <= dec_src1;
      alu_src2_e   <= dec_src2;
      imm_e        <= dec_imm;
      valid_e      <= 1'b1;
      illegal_e    <= dec_illegal;
    end
  end

endmodule
